// File: rtl/hydra_pkg.sv
// Shared constants and types for the write-back register file slice.
package hydra_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 2**ADDR_W;
  localparam int NPORTS = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: tracks registers owned by in-flight producers and
// raises stall on RAW/WAW hazards not resolved by this cycle's write-back.
module wb_scoreboard
  import hydra_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  reg_addr_t        wb_addr,
  input  logic             iss_valid,
  input  logic             iss_wr,
  input  reg_addr_t        iss_dst,
  input  reg_addr_t        rd_addr_a,
  input  reg_addr_t        rd_addr_b,
  input  logic             rd_use_a,
  input  logic             rd_use_b,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec
);
  reg_addr_t [NPORTS-1:0] rd_addr;
  logic      [NPORTS-1:0] rd_use;
  logic      [NPORTS-1:0] raw;
  logic                   waw;
  logic                   issue;
  logic      [NREGS-1:0]  busy_nxt;

  assign rd_addr = {rd_addr_b, rd_addr_a};
  assign rd_use  = {rd_use_b, rd_use_a};

  for (genvar p = 0; p < NPORTS; p++) begin : g_raw
    assign raw[p] = rd_use[p] & busy_vec[rd_addr[p]] & ~(wb_valid && (wb_addr == rd_addr[p]));
  end

  assign waw   = iss_wr & busy_vec[iss_dst] & ~(wb_valid && (wb_addr == iss_dst));
  assign stall = (|raw) | waw;
  assign issue = iss_valid & ~stall & iss_wr & (iss_dst != ZERO_REG);

  // Set is applied after clear so a new producer keeps ownership.
  always_comb begin
    busy_nxt = busy_vec;
    if (wb_valid) busy_nxt[wb_addr] = 1'b0;
    if (issue)    busy_nxt[iss_dst] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end
endmodule

// File: rtl/wb_reg_file.sv
// Register file fed by write-back: storage array, two bypassed read ports,
// and the hazard scoreboard that stalls decode.
module wb_reg_file
  import hydra_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_use_a,
  input  logic              rd_use_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec
);
  logic      [NREGS-1:0][DATA_W-1:0] regs;
  reg_addr_t [NPORTS-1:0]            rd_addr;
  reg_data_t [NPORTS-1:0]            rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n)                                regs          <= '0;
    else if (wb_valid && wb_addr != ZERO_REG)  regs[wb_addr] <= wb_data;
  end

  assign rd_addr = {rd_addr_b, rd_addr_a};

  // R0 is hard-wired; otherwise this cycle's write-back beats the stale array value.
  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    assign rd_data[p] = (rd_addr[p] == ZERO_REG)                ? '0 :
                        (wb_valid && wb_addr == rd_addr[p])      ? wb_data :
                                                                   regs[rd_addr[p]];
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

  wb_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .iss_valid (iss_valid),
    .iss_wr    (iss_wr),
    .iss_dst   (iss_dst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_use_a  (rd_use_a),
    .rd_use_b  (rd_use_b),
    .stall     (stall),
    .busy_vec  (busy_vec)
  );
endmodule
